// File: rtl/mc_block_sequencer.sv
// mc_block_sequencer: walks a frame in MB_SIZE blocks, turns ME vectors into MC reference origins.
// Define MC_SEQ_MV_CLAMP_EN to clamp reference origins so every MC access stays inside the frame.
module mc_block_sequencer #(
   parameter int MB_SIZE    = 4,
   parameter int FRAME_W    = 16,
   parameter int FRAME_H    = 16,
   parameter int MV_W       = 6,
   parameter int MC_LATENCY = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            done,
   input  logic            mv_valid,
   output logic            mv_ready,
   input  logic [MV_W-1:0] mv_x,
   input  logic [MV_W-1:0] mv_y,
   output logic [7:0]      blk_x,
   output logic [7:0]      blk_y,
   output logic [7:0]      ref_x,
   output logic [7:0]      ref_y,
   output logic            mc_start,
   output logic            res_valid,
   input  logic            res_ready
);
   typedef enum logic [2:0] {IDLE, WAIT_MV, ISSUE, WAIT_MC, OUT, DONE} state_t;
   localparam int CW = MC_LATENCY > 1 ? $clog2(MC_LATENCY) : 1;
   localparam logic [7:0] X_MAX = 8'(FRAME_W - MB_SIZE);
   localparam logic [7:0] Y_MAX = 8'(FRAME_H - MB_SIZE);
   localparam logic [7:0] STEP = 8'(MB_SIZE);
   state_t state;
   logic [CW-1:0] cnt;
   logic [7:0] nref_x, nref_y;
`ifdef MC_SEQ_MV_CLAMP_EN
   logic signed [9:0] sum_x, sum_y;
   always_comb begin
      sum_x = $signed({2'b00, blk_x}) + $signed({{(10-MV_W){mv_x[MV_W-1]}}, mv_x});
      sum_y = $signed({2'b00, blk_y}) + $signed({{(10-MV_W){mv_y[MV_W-1]}}, mv_y});
      nref_x = sum_x < 0 ? 8'd0 : (sum_x > $signed({2'b00, X_MAX}) ? X_MAX : sum_x[7:0]);
      nref_y = sum_y < 0 ? 8'd0 : (sum_y > $signed({2'b00, Y_MAX}) ? Y_MAX : sum_y[7:0]);
   end
`else
   // Unclamped origin wraps modulo 256; ME owns range checking.
   always_comb begin
      nref_x = blk_x + {{(8-MV_W){mv_x[MV_W-1]}}, mv_x};
      nref_y = blk_y + {{(8-MV_W){mv_y[MV_W-1]}}, mv_y};
   end
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         mv_ready  <= 1'b0;
         mc_start  <= 1'b0;
         res_valid <= 1'b0;
         blk_x     <= '0;
         blk_y     <= '0;
         ref_x     <= '0;
         ref_y     <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state    <= WAIT_MV;
               busy     <= 1'b1;
               mv_ready <= 1'b1;
               blk_x    <= '0;
               blk_y    <= '0;
            end
            WAIT_MV: if (mv_valid) begin
               state    <= ISSUE;
               mv_ready <= 1'b0;
               mc_start <= 1'b1;
               ref_x    <= nref_x;
               ref_y    <= nref_y;
            end
            ISSUE: begin
               state    <= WAIT_MC;
               mc_start <= 1'b0;
               cnt      <= CW'(MC_LATENCY - 1);
            end
            WAIT_MC: if (cnt == '0) begin
               state     <= OUT;
               res_valid <= 1'b1;
            end else
               cnt <= cnt - 1'b1;
            OUT: if (res_ready) begin
               res_valid <= 1'b0;
               if (blk_x < X_MAX) begin
                  blk_x    <= blk_x + STEP;
                  state    <= WAIT_MV;
                  mv_ready <= 1'b1;
               end else if (blk_y < Y_MAX) begin
                  blk_x    <= '0;
                  blk_y    <= blk_y + STEP;
                  state    <= WAIT_MV;
                  mv_ready <= 1'b1;
               end else begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_block_sequencer.sv
// tb_mc_block_sequencer: directed frames with random vectors, stalls and ignored-input noise.
module tb_mc_block_sequencer;
   localparam int MB = 4, FW = 16, FH = 16, MVW = 6, LAT = 1;
`ifdef MC_SEQ_MV_CLAMP_EN
   localparam bit CLAMP = 1'b1;
`else
   localparam bit CLAMP = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, mv_valid = 1'b0, res_ready = 1'b0;
   logic [MVW-1:0] mv_x = '0, mv_y = '0;
   logic busy, done, mv_ready, mc_start, res_valid;
   logic [7:0] blk_x, blk_y, ref_x, ref_y;
   int tests = 0, fails = 0, bx = 0, by = 0, ex = 0, ey = 0;
   bit noise = 1'b0;
   always #5 clk = ~clk;
   mc_block_sequencer #(.MB_SIZE(MB), .FRAME_W(FW), .FRAME_H(FH), .MV_W(MVW), .MC_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_x(mv_x), .mv_y(mv_y),
      .blk_x(blk_x), .blk_y(blk_y), .ref_x(ref_x), .ref_y(ref_y),
      .mc_start(mc_start), .res_valid(res_valid), .res_ready(res_ready)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   function automatic int clampv(input int v, input int lim);
      return v < 0 ? 0 : (v > lim ? lim : v);
   endfunction
   task automatic check_pos(input string tag);
      check({tag, "_blk_x"}, blk_x, bx);
      check({tag, "_blk_y"}, blk_y, by);
      check({tag, "_ref_x"}, ref_x, ex);
      check({tag, "_ref_y"}, ref_y, ey);
   endtask
   task automatic begin_frame();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bx = 0;
      by = 0;
      check("start_busy", busy, 1);
      check("start_mv_ready", mv_ready, 1);
      check("start_blk_x", blk_x, 0);
      check("start_blk_y", blk_y, 0);
      check("start_done", done, 0);
   endtask
   task automatic mv_hs(input int mvx, input int mvy, input int hold);
      for (int i = 0; i < hold; i++) begin
         mv_valid = 1'b0;
         @(negedge clk);
         check("mvwait_ready", mv_ready, 1);
         check("mvwait_mc_start", mc_start, 0);
      end
      check("mv_ready", mv_ready, 1);
      check("mv_res_valid", res_valid, 0);
      mv_x = MVW'(mvx);
      mv_y = MVW'(mvy);
      mv_valid = 1'b1;
      ex = CLAMP ? clampv(bx + mvx, FW - MB) : (bx + mvx) & 255;
      ey = CLAMP ? clampv(by + mvy, FH - MB) : (by + mvy) & 255;
      @(negedge clk);
      check("issue_mc_start", mc_start, 1);
      check("issue_mv_ready", mv_ready, 0);
      check_pos("issue");
      mv_valid = noise ? 1'($urandom) : 1'b0;
      mv_x = MVW'($urandom);
      mv_y = MVW'($urandom);
   endtask
   task automatic fin_blk(input int stall);
      int k = 0;
      bit last;
      while (!res_valid && k < 40) begin
         res_ready = noise ? 1'($urandom) : 1'b0;
         start = noise ? 1'($urandom) : 1'b0;
         @(negedge clk);
         k++;
         if (!res_valid) check("mc_wait_mc_start", mc_start, 0);
      end
      check("res_latency", k, LAT + 1);
      check("out_res_valid", res_valid, 1);
      check("out_mv_ready", mv_ready, 0);
      check_pos("out");
      for (int i = 0; i < stall; i++) begin
         res_ready = 1'b0;
         start = noise ? 1'($urandom) : 1'b0;
         mv_valid = noise ? 1'($urandom) : 1'b0;
         @(negedge clk);
         check("stall_res_valid", res_valid, 1);
         check("stall_mv_ready", mv_ready, 0);
         check("stall_mc_start", mc_start, 0);
         check_pos("stall");
      end
      start = 1'b0;
      res_ready = 1'b1;
      last = (bx == FW - MB) && (by == FH - MB);
      bx += MB;
      if (bx == FW) begin
         bx = 0;
         by += MB;
      end
      @(negedge clk);
      res_ready = noise ? 1'($urandom) : 1'b0;
      check("adv_res_valid", res_valid, 0);
      if (last) begin
         check("done_pulse", done, 1);
         check("done_busy", busy, 0);
         @(negedge clk);
         check("idle_done", done, 0);
         check("idle_busy", busy, 0);
         check("idle_mv_ready", mv_ready, 0);
      end else begin
         check("adv_done", done, 0);
         check("adv_busy", busy, 1);
         check("adv_mv_ready", mv_ready, 1);
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end
   initial begin
      int mvx, mvy, hold, stall;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mv_ready", mv_ready, 0);
      check("rst_mc_start", mc_start, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_blk", {blk_x, blk_y, ref_x, ref_y}, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_hold_busy", busy, 0);
      begin_frame();
      for (int b = 0; b < 16; b++) begin
         mv_hs(0, 0, 0);
         fin_blk(0);
      end
      noise = 1'b1;
      begin_frame();
      for (int b = 0; b < 16; b++) begin
         mvx = int'($urandom_range(0, 63)) - 32;
         mvy = int'($urandom_range(0, 63)) - 32;
         hold = int'($urandom_range(0, 2));
         stall = int'($urandom_range(0, 3));
         if (b == 0) begin mvx = -3; mvy = 0; end
         if (b == 1) stall = 5;
         if (b == 5) begin mvx = 3; mvy = -2; end
         if (b == 15) begin mvx = 5; mvy = 5; end
         mv_hs(mvx, mvy, hold);
         if (b == 0) begin
            check("edge0_ref_x", ref_x, CLAMP ? 0 : 253);
            check("edge0_ref_y", ref_y, 0);
         end
         if (b == 5) begin
            check("mid_ref_x", ref_x, 7);
            check("mid_ref_y", ref_y, 2);
         end
         if (b == 15) begin
            check("edge15_ref_x", ref_x, CLAMP ? 12 : 17);
            check("edge15_ref_y", ref_y, CLAMP ? 12 : 17);
         end
         fin_blk(stall);
      end
      noise = 1'b0;
      begin_frame();
      for (int b = 0; b < 6; b++) begin
         mv_hs(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32, 0);
         fin_blk(0);
      end
      mv_hs(1, 1, 0);
      check("rstblk_x", blk_x, 8);
      check("rstblk_y", blk_y, 4);
      @(negedge clk);
      check("wait_mc_res_valid", res_valid, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_mv_ready", mv_ready, 0);
      check("midrst_mc_start", mc_start, 0);
      check("midrst_res_valid", res_valid, 0);
      check("midrst_pos", {blk_x, blk_y, ref_x, ref_y}, 0);
      @(negedge clk);
      check("midrst_idle_done", done, 0);
      check("midrst_idle_busy", busy, 0);
      begin_frame();
      mv_hs(2, -1, 0);
      fin_blk(1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mc_block_sequencer.md
# mc_block_sequencer

Frame-level controller for the row-by-row motion-compensation datapath. It walks a frame in MB_SIZE×MB_SIZE blocks in raster order and accepts one motion vector per block from motion estimation. From that vector it computes the absolute reference-window origin, pulses the MC datapath, waits its fixed latency, and then presents the residual to the downstream transform stage with valid/ready backpressure. It sits between motion estimation and motion_compensation/transform in the inter-prediction path.

## Interface
Parameters:
- MB_SIZE, 4: block edge in pixels; power of two.
- FRAME_W, 16: frame width in pixels; multiple of MB_SIZE, ≤ 256.
- FRAME_H, 16: frame height in pixels; multiple of MB_SIZE, ≤ 256.
- MV_W, 6: motion-vector component width, signed two's complement.
- MC_LATENCY, 1: cycles from mc_start to residual valid at the MC output; ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begins a frame; sampled only in IDLE.
- busy  out  1  high from the start acceptance until the DONE state.
- done  out  1  single-cycle pulse after the last block's residual is accepted.
- mv_valid  in  1  ME vector available.
- mv_ready  out  1  high only in WAIT_MV.
- mv_x, mv_y  in  MV_W  signed displacement for the current block.
- blk_x, blk_y  out  8  current block origin, in pixels.
- ref_x, ref_y  out  8  absolute reference origin driven to MC.
- mc_start  out  1  one-cycle pulse; MC samples ref_x/ref_y.
- res_valid  out  1  residual of the current block is valid at the MC output.
- res_ready  in  1  downstream accepts the residual.

## Operation
- FSM states: IDLE, WAIT_MV, ISSUE, WAIT_MC, OUT, DONE.
- IDLE:
  - busy=0.
  - When start=1: clear blk_x and blk_y, then go to WAIT_MV.
- WAIT_MV:
  - mv_ready=1.
  - When mv_valid=1: latch mv_x/mv_y and compute ref_x/ref_y, then go to ISSUE.
  - mv_valid low keeps the FSM in WAIT_MV indefinitely.
- Reference origin arithmetic:
  - Form ref = blk + sign_extend(mv) in 10-bit signed.
  - The result passes through the clamp stage (see Configuration) and is registered into the 8-bit ref_x/ref_y.
- ISSUE:
  - mc_start=1 for exactly one cycle.
  - Load the latency counter with MC_LATENCY-1, then go to WAIT_MC.
- WAIT_MC:
  - Decrement the counter each cycle; go to OUT when it reaches 0.
  - With MC_LATENCY=1, WAIT_MC lasts one cycle.
- OUT:
  - res_valid=1 and held until res_ready=1.
  - On the handshake, advance the block position:
    - If blk_x < FRAME_W-MB_SIZE: blk_x += MB_SIZE, go to WAIT_MV.
    - Else, if blk_y < FRAME_H-MB_SIZE: blk_x=0, blk_y += MB_SIZE, go to WAIT_MV.
    - Else: go to DONE.
- DONE:
  - done=1 and busy=0 for one cycle, then go to IDLE.
- Output stability: blk_x, blk_y, ref_x and ref_y stay constant from ISSUE through the OUT handshake.
- Ignored inputs:
  - start outside IDLE is ignored.
  - mv_valid outside WAIT_MV is ignored; no vector is consumed.
- Blocks per frame: (FRAME_W/MB_SIZE)·(FRAME_H/MB_SIZE); 16 with the defaults.

## Timing
- Reset values: state=IDLE; busy, done, mv_ready, mc_start and res_valid are 0; blk_x, blk_y, ref_x and ref_y are 0.
- Reset is synchronous and active-high. Asserting reset mid-frame in any state returns the block to the reset values at the next edge and discards the in-flight block.
- start accepted at edge t → busy=1 and mv_ready=1 from t+1.
- MV handshake at edge t → mc_start high in cycle t+1 and res_valid high from cycle t+2+MC_LATENCY-1.
  - With the defaults this is 2 cycles from vector to residual valid.
- Per-block minimum with res_ready=1 and mv_valid=1 continuously: MC_LATENCY+3 cycles.
- The last res handshake at edge t → done pulse in cycle t+1, IDLE at t+2.
- mv_ready and res_valid are never high in the same cycle.

## Configuration
- MC_SEQ_MV_CLAMP_EN defined:
  - ref_x is clamped to [0, FRAME_W-MB_SIZE] and ref_y to [0, FRAME_H-MB_SIZE].
  - Every MC access therefore stays inside the frame.
- Not defined:
  - No clamp logic is built.
  - ref_x/ref_y = (blk + mv) mod 256, taken as the low 8 bits.
  - Range checking becomes ME's responsibility.

## Test plan
- Full frame: reset, then start with defaults, mv=(0,0), mv_valid=1 and res_ready=1 throughout.
  - Expect exactly 16 res handshakes with blk (0,0),(4,0),…,(12,0),(0,4),…,(12,12) and ref equal to blk for each.
  - Expect one done pulse, then busy=0.
- In-range MV: at blk (4,4) with mv=(+3,−2).
  - Expect ref=(7,2) and mc_start one cycle after the MV handshake.
  - Expect res_valid two cycles after the MV handshake.
- Clamp, macro defined:
  - blk (12,12), mv=(+5,+5) → ref=(12,12).
  - blk (0,0), mv=(−3,0) → ref=(0,0).
- Clamp, macro undefined:
  - blk (12,12), mv=(+5,+5) → ref=(17,17).
  - blk (0,0), mv=(−3,0) → ref=(253,0).
- Backpressure: hold res_ready=0 for 5 cycles in OUT.
  - Expect res_valid held and blk/ref unchanged.
  - Expect mv_ready=0 and no mc_start during those cycles.
  - Release res_ready → advance to the next block.
- Control edge cases:
  - A start pulse while busy is ignored, and a frame in flight continues unaffected.
  - Reset asserted in WAIT_MC at blk (8,4) → next cycle IDLE, all outputs 0, and no done pulse.
  - A new start then begins again at blk (0,0).
